// File: rtl/vga_sync_fifo_fwft_cfg_if.sv
// Handshake/data bundle between a producer/consumer and vga_sync_fifo_fwft_cfg.
// master = user side driving requests, slave = the FIFO.
interface vga_sync_fifo_fwft_cfg_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned AWIDTH = 4
);
    logic              write;
    logic [WIDTH-1:0]  din;
    logic              full;
    logic              afull;
    logic              read;
    logic [WIDTH-1:0]  dout;
    logic              empty;
    logic              aempty;
    logic [AWIDTH:0]   count;
    logic              clr_err;
    logic              overflow;
    logic              underflow;

    modport master (
        output write, din, read, clr_err,
        input  full, afull, dout, empty, aempty, count, overflow, underflow
    );

    modport slave (
        input  write, din, read, clr_err,
        output full, afull, dout, empty, aempty, count, overflow, underflow
    );
endinterface

// File: rtl/vga_sync_fifo_fwft_cfg.sv
// Single-clock FIFO with selectable FWFT / standard read port, occupancy count,
// programmable almost-full/almost-empty and sticky overflow/underflow flags.
module vga_sync_fifo_fwft_cfg #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AWIDTH       = $clog2(DEPTH),
    parameter int unsigned AFULL_THRES  = 1,
    parameter int unsigned AEMPTY_THRES = 1,
    parameter int unsigned FWFT         = 1
) (
    input  logic clk,
    input  logic rst_n,
    vga_sync_fifo_fwft_cfg_if.slave bus
);

    localparam int unsigned CW = AWIDTH + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOADED = 1'b1
    } pre_state_e;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    pre_state_e        state_q, state_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              wr_acc_c;
    logic              rd_acc_c;
    logic              pop_c;
    logic [CW-1:0]     stor_cnt_c;

    // Next-state: acceptance, preload/pop decision, count and flag decode.
    always_comb begin
        wr_acc_c    = bus.write & ~full_q;
        rd_acc_c    = bus.read & ~empty_q;
        stor_cnt_c  = count_q - ((state_q == ST_LOADED) ? CW'(1) : CW'(0));
        pop_c       = 1'b0;
        state_d     = state_q;
        dout_d      = dout_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        // Output-word pop: storage only, never bypassing a same-cycle write.
        if (FWFT != 0) begin
            case (state_q)
                ST_IDLE: begin
                    if (stor_cnt_c != CW'(0)) begin
                        pop_c   = 1'b1;
                        state_d = ST_LOADED;
                    end
                end
                ST_LOADED: begin
                    if (rd_acc_c) begin
                        if (stor_cnt_c != CW'(0)) begin
                            pop_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            pop_c = rd_acc_c;
        end

        if (pop_c) begin
            dout_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AWIDTH'(1);
        end
        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + AWIDTH'(1);
        end

        case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d   = (count_d == CW'(DEPTH));
        afull_d  = (count_d >= CW'(DEPTH - AFULL_THRES));
        aempty_d = (count_d <= CW'(AEMPTY_THRES));
        empty_d  = (FWFT != 0) ? (state_d != ST_LOADED) : (count_d == CW'(0));

        // Error event beats a same-cycle clear.
        overflow_d  = (bus.write & full_q)  | (overflow_q  & ~bus.clr_err);
        underflow_d = (bus.read  & empty_q) | (underflow_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            dout_q      <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            dout_q      <= dout_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array carries no reset; reset pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.afull     = afull_q;
    assign bus.aempty    = aempty_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_vga_sync_fifo_fwft_cfg.sv
// Randomized + directed bench for vga_sync_fifo_fwft_cfg: one FWFT instance
// (thresholds 2/3) and one standard-read instance, both checked against queue models.
module tb_vga_sync_fifo_fwft_cfg;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 16;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_sync_fifo_fwft_cfg_if #(.WIDTH(W), .AWIDTH(AW)) fb ();
    vga_sync_fifo_fwft_cfg_if #(.WIDTH(W), .AWIDTH(AW)) sb ();

    vga_sync_fifo_fwft_cfg #(
        .WIDTH(W), .DEPTH(D), .AWIDTH(AW),
        .AFULL_THRES(2), .AEMPTY_THRES(3), .FWFT(1)
    ) u_fwft (.clk(clk), .rst_n(rst_n), .bus(fb));

    vga_sync_fifo_fwft_cfg #(
        .WIDTH(W), .DEPTH(D), .AWIDTH(AW),
        .AFULL_THRES(1), .AEMPTY_THRES(1), .FWFT(0)
    ) u_std (.clk(clk), .rst_n(rst_n), .bus(sb));

    int checks = 0;
    int errors = 0;

    // Reference models: FWFT = stored words + a presented word; standard = plain queue.
    logic [W-1:0] fq[$];
    bit           f_port;
    logic [W-1:0] f_dout;
    bit           f_ovf, f_udf;
    logic [W-1:0] sq[$];
    logic [W-1:0] s_dout;
    bit           s_ovf, s_udf;

    function automatic int f_cnt();
        return fq.size() + int'(f_port);
    endfunction

    function automatic void model_reset();
        fq.delete(); f_port = 0; f_dout = '0; f_ovf = 0; f_udf = 0;
        sq.delete(); s_dout = '0; s_ovf = 0; s_udf = 0;
    endfunction

    function automatic void model_step();
        bit fw, fr, sw, sr;
        fw = fb.write && (f_cnt() != D);
        fr = fb.read && f_port;
        if (fb.write && f_cnt() == D) f_ovf = 1; else if (fb.clr_err) f_ovf = 0;
        if (fb.read && !f_port)       f_udf = 1; else if (fb.clr_err) f_udf = 0;
        if ((!f_port || fr) && fq.size() > 0) begin
            f_dout = fq.pop_front();
            f_port = 1;
        end else if (fr) begin
            f_port = 0;
        end
        if (fw) fq.push_back(fb.din);

        sw = sb.write && (sq.size() != D);
        sr = sb.read && (sq.size() != 0);
        if (sb.write && sq.size() == D) s_ovf = 1; else if (sb.clr_err) s_ovf = 0;
        if (sb.read && sq.size() == 0)  s_udf = 1; else if (sb.clr_err) s_udf = 0;
        if (sr) s_dout = sq.pop_front();
        if (sw) sq.push_back(sb.din);
    endfunction

    task automatic idle();
        fb.write = 0; fb.read = 0; fb.clr_err = 0; fb.din = '0;
        sb.write = 0; sb.read = 0; sb.clr_err = 0; sb.din = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 40; i++) begin
            idle();
            fb.read = f_port;
            sb.read = (sq.size() != 0);
            if (f_cnt() == 0 && sq.size() == 0) break;
            tick();
        end
        idle();
        fb.clr_err = 1; sb.clr_err = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        checks++;
        if ({fb.count, fb.empty, fb.full, fb.afull, fb.aempty, fb.overflow, fb.underflow} !== {5'd0, 6'b100100}) begin
            errors++;
            $display("FAIL reset_fwft_flags got cnt=%0d e=%b f=%b af=%b ae=%b of=%b uf=%b exp cnt=0 e=1 f=0 af=0 ae=1 of=0 uf=0",
                     fb.count, fb.empty, fb.full, fb.afull, fb.aempty, fb.overflow, fb.underflow);
        end
        checks++;
        if ({sb.count, sb.empty, sb.full, sb.afull, sb.aempty, sb.overflow, sb.underflow} !== {5'd0, 6'b100100}) begin
            errors++;
            $display("FAIL reset_std_flags got cnt=%0d e=%b f=%b af=%b ae=%b exp cnt=0 e=1 f=0 af=0 ae=1",
                     sb.count, sb.empty, sb.full, sb.afull, sb.aempty);
        end
        checks++;
        if (fb.dout !== 32'h0 || sb.dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_dout got fwft=%h std=%h exp 0", fb.dout, sb.dout);
        end
    endtask

    task automatic test_first_word();
        idle(); fb.write = 1; fb.din = 32'h11;
        tick(); idle();
        checks++;
        if (fb.count !== 5'd1 || fb.empty !== 1'b1) begin
            errors++;
            $display("FAIL first_word_E got cnt=%0d empty=%b exp cnt=1 empty=1", fb.count, fb.empty);
        end
        tick();
        checks++;
        if (fb.empty !== 1'b0 || fb.dout !== 32'h11) begin
            errors++;
            $display("FAIL first_word_E1 got empty=%b dout=%h exp empty=0 dout=11", fb.empty, fb.dout);
        end
        fb.read = 1;
        tick(); idle();
        checks++;
        if (fb.count !== 5'd0 || fb.empty !== 1'b1 || fb.dout !== 32'h11) begin
            errors++;
            $display("FAIL first_word_read got cnt=%0d empty=%b dout=%h exp 0 1 11", fb.count, fb.empty, fb.dout);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            idle(); fb.write = 1; fb.din = W'(i);
            tick();
            checks++;
            if (fb.count !== 5'(i + 1)) begin
                errors++;
                $display("FAIL fill_count got %0d exp %0d", fb.count, i + 1);
            end
        end
        checks++;
        if (fb.full !== 1'b1 || fb.overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got full=%b ovf=%b exp 1 0", fb.full, fb.overflow);
        end
        fb.din = 32'h99;
        tick(); idle();
        checks++;
        if (fb.overflow !== 1'b1 || fb.count !== 5'd16) begin
            errors++;
            $display("FAIL overflow_set got ovf=%b cnt=%0d exp 1 16", fb.overflow, fb.count);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (fb.empty !== 1'b0 || fb.dout !== W'(i)) begin
                errors++;
                $display("FAIL fill_readout got empty=%b dout=%h exp empty=0 dout=%h", fb.empty, fb.dout, W'(i));
            end
            fb.read = 1;
            tick();
        end
        idle();
        checks++;
        if (fb.count !== 5'd0 || fb.empty !== 1'b1 || fb.overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_drained got cnt=%0d empty=%b ovf=%b exp 0 1 1", fb.count, fb.empty, fb.overflow);
        end
        fb.clr_err = 1;
        tick(); idle();
        checks++;
        if (fb.overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got %b exp 0", fb.overflow);
        end
    endtask

    task automatic test_underflow();
        idle(); fb.read = 1;
        tick(); idle();
        checks++;
        if (fb.underflow !== 1'b1 || fb.count !== 5'd0) begin
            errors++;
            $display("FAIL underflow_set got uf=%b cnt=%0d exp 1 0", fb.underflow, fb.count);
        end
        fb.clr_err = 1;
        tick(); idle();
        checks++;
        if (fb.underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear got %b exp 0", fb.underflow);
        end
        fb.read = 1; fb.clr_err = 1;
        tick(); idle();
        checks++;
        if (fb.underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_vs_clr got %b exp 1", fb.underflow);
        end
        fb.clr_err = 1;
        tick(); idle();
    endtask

    task automatic test_thresholds();
        for (int k = 1; k <= 14; k++) begin
            idle(); fb.write = 1; fb.din = $urandom;
            tick();
            checks++;
            if (fb.count !== 5'(k) || fb.afull !== (k >= 14) || fb.aempty !== (k <= 3)) begin
                errors++;
                $display("FAIL thresholds got cnt=%0d afull=%b aempty=%b exp cnt=%0d afull=%b aempty=%b",
                         fb.count, fb.afull, fb.aempty, k, (k >= 14), (k <= 3));
            end
        end
        drain_all();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sent[$];
        for (int i = 0; i < 8; i++) begin
            idle(); fb.write = 1; fb.din = $urandom; sent.push_back(fb.din);
            tick();
        end
        idle();
        tick();
        for (int k = 0; k < 100; k++) begin
            checks++;
            if (fb.empty !== 1'b0 || fb.dout !== sent[k]) begin
                errors++;
                $display("FAIL stream_dout cycle %0d got empty=%b dout=%h exp empty=0 dout=%h", k, fb.empty, fb.dout, sent[k]);
            end
            fb.write = 1; fb.read = 1; fb.din = $urandom; sent.push_back(fb.din);
            tick();
            checks++;
            if (fb.count !== 5'd8) begin
                errors++;
                $display("FAIL stream_count cycle %0d got %0d exp 8", k, fb.count);
            end
        end
        drain_all();
    endtask

    task automatic test_random();
        int pw, pr;
        for (int i = 0; i < 400; i++) begin
            pw = (i < 100) ? 80 : (i < 200) ? 20 : 50;
            pr = 100 - pw;
            fb.write   = ($urandom_range(0, 99) < pw);
            fb.read    = ($urandom_range(0, 99) < pr);
            fb.clr_err = ($urandom_range(0, 99) < 5);
            fb.din     = $urandom;
            sb.write   = ($urandom_range(0, 99) < pw);
            sb.read    = ($urandom_range(0, 99) < pr);
            sb.clr_err = ($urandom_range(0, 99) < 5);
            sb.din     = $urandom;
            tick();
            checks++;
            if (fb.count !== 5'(f_cnt()) || fb.dout !== f_dout) begin
                errors++;
                $display("FAIL rand_fwft_data cycle %0d got cnt=%0d dout=%h exp cnt=%0d dout=%h", i, fb.count, fb.dout, f_cnt(), f_dout);
            end
            checks++;
            if ({fb.full, fb.afull, fb.empty, fb.aempty, fb.overflow, fb.underflow} !==
                {f_cnt() == D, f_cnt() >= D - 2, !f_port, f_cnt() <= 3, f_ovf, f_udf}) begin
                errors++;
                $display("FAIL rand_fwft_flags cycle %0d got f/af/e/ae/of/uf=%b%b%b%b%b%b exp %b%b%b%b%b%b", i,
                         fb.full, fb.afull, fb.empty, fb.aempty, fb.overflow, fb.underflow,
                         f_cnt() == D, f_cnt() >= D - 2, !f_port, f_cnt() <= 3, f_ovf, f_udf);
            end
            checks++;
            if (sb.count !== 5'(sq.size()) || sb.dout !== s_dout) begin
                errors++;
                $display("FAIL rand_std_data cycle %0d got cnt=%0d dout=%h exp cnt=%0d dout=%h", i, sb.count, sb.dout, sq.size(), s_dout);
            end
            checks++;
            if ({sb.full, sb.afull, sb.empty, sb.aempty, sb.overflow, sb.underflow} !==
                {sq.size() == D, sq.size() >= D - 1, sq.size() == 0, sq.size() <= 1, s_ovf, s_udf}) begin
                errors++;
                $display("FAIL rand_std_flags cycle %0d got f/af/e/ae/of/uf=%b%b%b%b%b%b exp %b%b%b%b%b%b", i,
                         sb.full, sb.afull, sb.empty, sb.aempty, sb.overflow, sb.underflow,
                         sq.size() == D, sq.size() >= D - 1, sq.size() == 0, sq.size() <= 1, s_ovf, s_udf);
            end
        end
        drain_all();
    endtask

    task automatic test_std_mode();
        idle(); sb.write = 1; sb.din = 32'hA;
        tick();
        checks++;
        if (sb.count !== 5'd1 || sb.empty !== 1'b0) begin
            errors++;
            $display("FAIL std_write got cnt=%0d empty=%b exp 1 0", sb.count, sb.empty);
        end
        sb.din = 32'hB;
        tick(); idle();
        sb.read = 1;
        tick(); idle();
        checks++;
        if (sb.dout !== 32'hA || sb.count !== 5'd1) begin
            errors++;
            $display("FAIL std_read_a got dout=%h cnt=%0d exp a 1", sb.dout, sb.count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sb.dout !== 32'hA) begin
                errors++;
                $display("FAIL std_hold got dout=%h exp a", sb.dout);
            end
        end
        sb.read = 1;
        tick(); idle();
        checks++;
        if (sb.dout !== 32'hB || sb.empty !== 1'b1) begin
            errors++;
            $display("FAIL std_read_b got dout=%h empty=%b exp b 1", sb.dout, sb.empty);
        end
        sb.write = 1; sb.din = 32'hC;
        tick();
        sb.read = 1; sb.din = 32'hD;
        tick(); idle();
        checks++;
        if (sb.dout !== 32'hC || sb.count !== 5'd1) begin
            errors++;
            $display("FAIL std_rw_same got dout=%h cnt=%0d exp c 1", sb.dout, sb.count);
        end
        sb.read = 1;
        tick(); idle();
        checks++;
        if (sb.dout !== 32'hD || sb.count !== 5'd0) begin
            errors++;
            $display("FAIL std_rw_order got dout=%h cnt=%0d exp d 0", sb.dout, sb.count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            idle(); fb.write = 1; sb.write = 1; fb.din = 32'h100 + W'(i); sb.din = 32'h200 + W'(i);
            tick();
        end
        idle();
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (fb.count !== 5'd0 || fb.empty !== 1'b1 || fb.dout !== 32'h0 || sb.count !== 5'd0 || sb.empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got fcnt=%0d fempty=%b fdout=%h scnt=%0d sempty=%b exp 0 1 0 0 1",
                     fb.count, fb.empty, fb.dout, sb.count, sb.empty);
        end
        @(negedge clk);
        rst_n = 1;
        fb.write = 1; sb.write = 1; fb.din = 32'h55; sb.din = 32'h66;
        tick(); idle();
        tick();
        checks++;
        if (fb.dout !== 32'h55 || fb.count !== 5'd1 || fb.empty !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_fwft_new got dout=%h cnt=%0d empty=%b exp 55 1 0", fb.dout, fb.count, fb.empty);
        end
        sb.read = 1;
        tick(); idle();
        checks++;
        if (sb.dout !== 32'h66 || sb.count !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset_std_new got dout=%h cnt=%0d exp 66 0", sb.dout, sb.count);
        end
        drain_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        #12;
        test_reset();
        rst_n = 1;
        #1;
        test_reset();
        test_first_word();
        test_fill_overflow();
        test_underflow();
        test_thresholds();
        test_back_to_back();
        test_std_mode();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
